audio_write_sequencer: RTL and testbench
========================================

// Module: audio_write_sequencer
// PURPOSE
//  Synthesisable, queued register-write engine for the SID-style audio block. Sits between a host
//  (SPI bridge or test ROM) and audio's rw_n/addr/data bus. Buffers commands in a FIFO and issues
//  each WRITE as exactly one cpu_en-qualified bus write. Adds timed WAITs in cpu_en strobes and MARK
//  events, so note sequences (freq, ADSR, gate on/off) replay with strobe-exact timing.
// PARAMETERS
//  DEPTH   16  command FIFO entries; power of two, >=2
//  ADDR_W  5   audio register address width
//  DATA_W  8   audio register data width
//  WAIT_W  ADDR_W+DATA_W  WAIT count width; WAIT uses the {addr,data} fields as one count
// PORTS
//  clk8_i       in   1       system clock; same clock as audio.clk8_i
//  reset_i      in   1       asynchronous, active-high reset
//  cpu_en_i     in   1       bus strobe; audio samples its bus on clk8_i edges where cpu_en_i=1
//  cmd_valid_i  in   1       host command valid
//  cmd_ready_o  out  1       FIFO not full; command accepted when valid & ready
//  cmd_op_i     in   2       opcode: 0 WRITE, 1 WAIT, 2 MARK, 3 reserved (treated as no-op)
//  cmd_addr_i   in   ADDR_W  WRITE address / WAIT count high bits
//  cmd_data_i   in   DATA_W  WRITE data / WAIT count low bits / MARK tag
//  flush_i      in   1       drop queued commands, abort active WAIT
//  rw_no        out  1       to audio.rw_ni; 0 = write
//  addr_o       out  ADDR_W  to audio.addr_i
//  data_o       out  DATA_W  to audio.data_i
//  mark_o       out  1       one-cycle pulse when a MARK executes
//  mark_tag_o   out  DATA_W  tag of the last MARK; held until the next MARK
//  busy_o       out  1       FIFO non-empty or state != IDLE
//  level_o      out  $clog2(DEPTH)+1  FIFO occupancy
// BEHAVIOUR
//  Reset values: rw_no=1, addr_o=0, data_o=0, mark_o=0, mark_tag_o=0, busy_o=0, level_o=0,
//   cmd_ready_o=1, FIFO empty, state IDLE, wait counter 0. All outputs are registered.
//  FSM states: IDLE, WR_HOLD, WAITING.
//  IDLE: if FIFO non-empty, pop one entry this cycle and decode:
//   WRITE: next cycle addr_o/data_o <= fields, rw_no <= 0, go to WR_HOLD.
//   WAIT n: n==0 stays IDLE (1-cycle cost). Otherwise cnt <= n, go to WAITING.
//   MARK: next cycle mark_o=1, mark_tag_o=tag. Stay IDLE.
//   op 3: discarded, stay IDLE.
//  WR_HOLD: addr_o/data_o/rw_no held. On the first cycle with cpu_en_i=1, that cycle is the sample
//   cycle. The next edge sets rw_no <= 1 and returns to IDLE. Exactly one cpu_en_i=1 cycle sees
//   rw_no=0 per WRITE, with addr/data stable for the whole cycle. addr_o/data_o keep their value after.
//  WAITING: on each cycle with cpu_en_i=1, cnt <= cnt-1. When it decrements 1->0, go to IDLE.
//   The next command pops on the following cycle. WAIT n spans exactly n cpu_en strobes.
//  Back-to-back WRITEs: rw_no is high for >=1 cycle between them. At most one write per strobe.
//  FIFO: push when cmd_valid_i & cmd_ready_o. Simultaneous push+pop is allowed; level unchanged.
//   Push when full is ignored (ready=0). Pointers wrap mod DEPTH.
//  flush_i (synchronous, one cycle):
//   FIFO empties and level_o=0 next cycle; a push in the same cycle is dropped.
//   WAITING returns to IDLE.
//   WR_HOLD is NOT aborted; the write completes, so no register is half-written.
//  reset_i mid-write: rw_no goes to 1 asynchronously. The bus write is lost; host re-sends.
//  Arithmetic: cnt is WAIT_W bits unsigned; never decrements below 0.
// STRUCTURE
//  audio_seq_pkg: op_e enum (OP_WRITE/OP_WAIT/OP_MARK/OP_NOP), cmd_t struct {op,addr,data},
//   state_e, and audio register address constants (V1_FREQ_LO=0, V1_FREQ_HI=1, V1_CTRL=4,
//   V1_AD=5, V1_SR=6, MODE_VOL=24).
//  One sub-module: sync_fifo #(WIDTH=$bits(cmd_t), DEPTH), with flush, full/empty/level.
//  Top level: FSM, wait counter, output registers.
// TESTING
//  1 WRITE(24,8'h1F) -> exactly one cpu_en_i=1 cycle with rw_no=0, addr_o=24, data_o=8'h1F;
//    audio mode/vol register reads back 4'hF.
//  2 WRITE(0,8'h34), WAIT 3, WRITE(1,8'h12) -> the two write strobes are exactly 4 cpu_en strobes
//    apart; WAIT 0 adds no strobe.
//  3 Push 16 commands with FSM stalled in WAIT -> cmd_ready_o=0 at level 16. 17th push ignored.
//    Pop+push in one cycle keeps level constant.
//  4 flush_i during WAIT 100 with 5 queued -> level_o=0 and IDLE next cycle; no further writes.
//  5 flush_i and reset_i during WR_HOLD -> flush: write still completes; reset: rw_no=1 immediately,
//    all outputs at reset values.
//  6 MARK tag 8'hA5 between writes -> mark_o high one cycle after the preceding write's rw_no
//    release; mark_tag_o=8'hA5.

Source files
------------

// File: rtl/audio_seq_pkg.sv
// Shared types and register map for the audio write sequencer.
package audio_seq_pkg;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 8;
    localparam int WAIT_W = ADDR_W + DATA_W;

    typedef enum logic [1:0] {
        OP_WRITE = 2'd0,
        OP_WAIT  = 2'd1,
        OP_MARK  = 2'd2,
        OP_NOP   = 2'd3
    } op_e;

    typedef struct packed {
        op_e               op;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } cmd_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WR_HOLD = 2'd1,
        ST_WAITING = 2'd2
    } state_e;

    localparam logic [ADDR_W-1:0] V1_FREQ_LO = 5'd0;
    localparam logic [ADDR_W-1:0] V1_FREQ_HI = 5'd1;
    localparam logic [ADDR_W-1:0] V1_CTRL    = 5'd4;
    localparam logic [ADDR_W-1:0] V1_AD      = 5'd5;
    localparam logic [ADDR_W-1:0] V1_SR      = 5'd6;
    localparam logic [ADDR_W-1:0] MODE_VOL   = 5'd24;

    // A WAIT reuses both payload fields as one strobe count.
    function automatic logic [WAIT_W-1:0] wait_count(input cmd_t c);
        return {c.addr, c.data};
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO, head visible combinationally; registered level/full/empty, 1-cycle push-to-pop.
// Pushes while full are dropped; flush empties it in one cycle and wins over a same-cycle push or pop.
module sync_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wr_dat_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rd_dat_o,
    output logic             full_o,
    output logic             empty_o,
    output logic             empty_nxt_o,
    output logic [AW:0]      level_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             full_q, full_d, empty_q, empty_d;
    logic             do_push, do_pop;

    assign do_push = push_i & ~full_q & ~flush_i;
    assign do_pop  = pop_i & ~empty_q & ~flush_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + (AW+1)'(1);
                2'b01:   count_d = count_q - (AW+1)'(1);
                default: count_d = count_q;
            endcase
        end
        full_d  = (count_d == (AW+1)'(DEPTH));
        empty_d = (count_d == '0);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= wr_dat_i;
    end

    assign rd_dat_o    = mem_q[rd_ptr_q];
    assign full_o      = full_q;
    assign empty_o     = empty_q;
    assign empty_nxt_o = empty_d;
    assign level_o     = count_q;

endmodule

// File: rtl/audio_write_sequencer.sv
// Queued register-write engine: WRITE reaches the bus one cycle after pop and is held until one cpu_en strobe samples it.
// Host backpressure is cmd_ready_o (FIFO not full); WAIT stalls the queue for n strobes, flush drops it.
module audio_write_sequencer
    import audio_seq_pkg::*;
#(
    parameter  int DEPTH = 16,
    localparam int LW    = $clog2(DEPTH) + 1
) (
    input  logic              clk8_i,
    input  logic              reset_i,
    input  logic              cpu_en_i,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic [1:0]        cmd_op_i,
    input  logic [ADDR_W-1:0] cmd_addr_i,
    input  logic [DATA_W-1:0] cmd_data_i,
    input  logic              flush_i,
    output logic              rw_no,
    output logic [ADDR_W-1:0] addr_o,
    output logic [DATA_W-1:0] data_o,
    output logic              mark_o,
    output logic [DATA_W-1:0] mark_tag_o,
    output logic              busy_o,
    output logic [LW-1:0]     level_o
);

    state_e            state_q, state_d;
    logic [WAIT_W-1:0] cnt_q, cnt_d;
    logic              rw_no_q, rw_no_d, mark_q, mark_d, busy_q, busy_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d, tag_q, tag_d;

    cmd_t cmd_in, head;
    logic fifo_full, fifo_empty, fifo_empty_nxt, pop;

    assign cmd_in = cmd_t'({cmd_op_i, cmd_addr_i, cmd_data_i});
    // The queue only advances from IDLE, and never in a flush cycle.
    assign pop    = (state_q == ST_IDLE) & ~fifo_empty & ~flush_i;

    sync_fifo #(
        .WIDTH ($bits(cmd_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i       (clk8_i),
        .rst_i       (reset_i),
        .flush_i     (flush_i),
        .push_i      (cmd_valid_i & cmd_ready_o),
        .wr_dat_i    (cmd_in),
        .pop_i       (pop),
        .rd_dat_o    (head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .empty_nxt_o (fifo_empty_nxt),
        .level_o     (level_o)
    );

    always_ff @(posedge clk8_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            rw_no_q <= 1'b1;
            addr_q  <= '0;
            data_q  <= '0;
            mark_q  <= 1'b0;
            tag_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rw_no_q <= rw_no_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            mark_q  <= mark_d;
            tag_q   <= tag_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (pop) begin
                    case (head.op)
                        OP_WRITE: state_d = ST_WR_HOLD;
                        OP_WAIT: begin
                            if (wait_count(head) != '0) begin
                                cnt_d   = wait_count(head);
                                state_d = ST_WAITING;
                            end
                        end
                        default: state_d = ST_IDLE;
                    endcase
                end
            end
            // Flush deliberately does not abort a held write.
            ST_WR_HOLD: begin
                if (cpu_en_i) state_d = ST_IDLE;
            end
            ST_WAITING: begin
                if (flush_i) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else if (cpu_en_i && cnt_q != '0) begin
                    cnt_d = cnt_q - WAIT_W'(1);
                    if (cnt_q == WAIT_W'(1)) state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        rw_no_d = rw_no_q;
        addr_d  = addr_q;
        data_d  = data_q;
        mark_d  = 1'b0;
        tag_d   = tag_q;
        if (pop && head.op == OP_WRITE) begin
            addr_d  = head.addr;
            data_d  = head.data;
            rw_no_d = 1'b0;
        end else if (pop && head.op == OP_MARK) begin
            mark_d = 1'b1;
            tag_d  = head.data;
        end else if (state_q == ST_WR_HOLD && cpu_en_i) begin
            rw_no_d = 1'b1;
        end
        busy_d = (state_d != ST_IDLE) | ~fifo_empty_nxt;
    end

    assign cmd_ready_o = ~fifo_full;
    assign rw_no       = rw_no_q;
    assign addr_o      = addr_q;
    assign data_o      = data_q;
    assign mark_o      = mark_q;
    assign mark_tag_o  = tag_q;
    assign busy_o      = busy_q;

endmodule

// File: tb/tb_audio_write_sequencer.sv
// Bench for audio_write_sequencer: queue-level reference model compared every cycle, plus directed literal checks.
module tb_audio_write_sequencer;
    import audio_seq_pkg::*;

    localparam int DEPTH = 16;

    logic       clk8 = 1'b0;
    logic       reset_i = 1'b1;
    logic       cpu_en_i = 1'b0;
    logic       cmd_valid_i = 1'b0;
    logic       flush_i = 1'b0;
    logic [1:0] cmd_op_i = 2'd0;
    logic [4:0] cmd_addr_i = 5'd0;
    logic [7:0] cmd_data_i = 8'd0;
    logic       cmd_ready_o, rw_no, mark_o, busy_o;
    logic [4:0] addr_o, level_o;
    logic [7:0] data_o, mark_tag_o;

    audio_write_sequencer #(.DEPTH(DEPTH)) dut (
        .clk8_i(clk8), .reset_i(reset_i), .cpu_en_i(cpu_en_i),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_op_i(cmd_op_i),
        .cmd_addr_i(cmd_addr_i), .cmd_data_i(cmd_data_i), .flush_i(flush_i),
        .rw_no(rw_no), .addr_o(addr_o), .data_o(data_o), .mark_o(mark_o),
        .mark_tag_o(mark_tag_o), .busy_o(busy_o), .level_o(level_o)
    );

    always #5 clk8 = ~clk8;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0t", name, act, exp, $time);
        end
    endtask

    // Strobe source: 0 off, 1 every 4th cycle, 2 random.
    int en_mode = 0;
    int cyc = 0;
    always @(posedge clk8) begin
        #2;
        case (en_mode)
            1:       cpu_en_i = (cyc % 4 == 0);
            2:       cpu_en_i = ($urandom_range(0, 2) == 0);
            default: cpu_en_i = 1'b0;
        endcase
    end

    // Reference model: a command queue, a pending-write flag and a remaining-strobe count.
    typedef struct { int op; int addr; int data; } mcmd_t;
    mcmd_t mq[$];
    bit m_pend = 0;
    int m_wait = 0;
    bit exp_rw = 1, exp_mark = 0;
    int exp_addr = 0, exp_data = 0, exp_tag = 0;

    // Bus observer: emulated audio register file and write log.
    logic [7:0] regs [32];
    int strobe_cnt = 0, nwr = 0, nmark = 0, last_rel = -100, mark_gap = -1;
    int wr_strobe[$], wr_addr[$];
    logic prev_rw = 1'b1;

    always @(negedge clk8) begin
        mcmd_t c;
        int sz;
        bit can_push;
        cyc++;
        if (cpu_en_i) strobe_cnt++;
        if (cpu_en_i && !rw_no) begin
            regs[addr_o] = data_o;
            wr_strobe.push_back(strobe_cnt);
            wr_addr.push_back(int'(addr_o));
            nwr++;
        end
        if (rw_no && !prev_rw) last_rel = cyc;
        prev_rw = rw_no;
        if (mark_o) begin
            nmark++;
            mark_gap = cyc - last_rel;
        end

        if (reset_i) begin
            mq.delete();
            m_pend = 0; m_wait = 0;
            exp_rw = 1; exp_addr = 0; exp_data = 0; exp_mark = 0; exp_tag = 0;
        end else begin
            sz = mq.size();
            can_push = cmd_valid_i && sz < DEPTH && !flush_i;
            exp_mark = 0;
            if (m_pend) begin
                if (cpu_en_i) begin m_pend = 0; exp_rw = 1; end
            end else if (m_wait > 0) begin
                if (flush_i) m_wait = 0;
                else if (cpu_en_i) m_wait--;
            end else if (sz > 0 && !flush_i) begin
                c = mq.pop_front();
                case (c.op)
                    0: begin m_pend = 1; exp_rw = 0; exp_addr = c.addr; exp_data = c.data; end
                    1: m_wait = c.addr * 256 + c.data;
                    2: begin exp_mark = 1; exp_tag = c.data; end
                    default: ;
                endcase
            end
            if (flush_i) mq.delete();
            else if (can_push)
                mq.push_back('{int'(cmd_op_i), int'(cmd_addr_i), int'(cmd_data_i)});
        end
    end

    always @(posedge clk8) begin
        #1;
        chk("rw_no",       32'(rw_no),       32'(exp_rw));
        chk("addr_o",      32'(addr_o),      32'(exp_addr));
        chk("data_o",      32'(data_o),      32'(exp_data));
        chk("mark_o",      32'(mark_o),      32'(exp_mark));
        chk("mark_tag_o",  32'(mark_tag_o),  32'(exp_tag));
        chk("level_o",     32'(level_o),     32'(mq.size()));
        chk("cmd_ready_o", 32'(cmd_ready_o), 32'(mq.size() < DEPTH));
        chk("busy_o",      32'(busy_o),      32'(mq.size() > 0 || m_pend || m_wait > 0));
    end

    task automatic put(input logic [1:0] op, input logic [4:0] a, input logic [7:0] d);
        @(posedge clk8); #2;
        cmd_valid_i = 1'b1; cmd_op_i = op; cmd_addr_i = a; cmd_data_i = d; flush_i = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk8); #2;
            cmd_valid_i = 1'b0; flush_i = 1'b0;
        end
    endtask

    task automatic pulse_flush();
        @(posedge clk8); #2;
        cmd_valid_i = 1'b0; flush_i = 1'b1;
        @(posedge clk8); #2;
        flush_i = 1'b0;
    endtask

    initial begin
        int n0;
        idle(3);
        reset_i = 1'b0;
        chk("reset rw_no", 32'(rw_no), 32'd1);
        chk("reset busy", 32'(busy_o), 32'd0);

        // Single write to the mode/volume register.
        en_mode = 1;
        n0 = nwr;
        put(OP_WRITE, MODE_VOL, 8'h1F);
        idle(30);
        chk("t1 write count", 32'(nwr - n0), 32'd1);
        chk("t1 mode_vol vol", 32'(regs[MODE_VOL][3:0]), 32'hF);
        chk("t1 mode_vol", 32'(regs[MODE_VOL]), 32'h1F);

        // WRITE, WAIT 0, WAIT 3, WRITE: strobes four apart.
        n0 = wr_strobe.size();
        put(OP_WRITE, V1_FREQ_LO, 8'h34);
        put(OP_WAIT, 5'd0, 8'd0);
        put(OP_WAIT, 5'd0, 8'd3);
        put(OP_WRITE, V1_FREQ_HI, 8'h12);
        idle(80);
        chk("t2 write count", 32'(wr_strobe.size() - n0), 32'd2);
        if (wr_strobe.size() >= n0 + 2) begin
            chk("t2 first addr", 32'(wr_addr[n0]), 32'd0);
            chk("t2 second addr", 32'(wr_addr[n0+1]), 32'd1);
            chk("t2 strobe gap", 32'(wr_strobe[n0+1] - wr_strobe[n0]), 32'd4);
        end

        // Fill the FIFO behind a stalled WAIT; the 17th push is refused.
        en_mode = 0;
        put(OP_WAIT, 5'd0, 8'd100);
        idle(3);
        for (int i = 0; i < 17; i++) put(OP_WRITE, V1_CTRL, 8'(i));
        idle(1);
        chk("t3 level full", 32'(level_o), 32'd16);
        chk("t3 ready low", 32'(cmd_ready_o), 32'd0);
        pulse_flush();
        chk("t3 flushed level", 32'(level_o), 32'd0);

        // Flush during WAIT 100 with five queued.
        put(OP_WAIT, 5'd0, 8'd100);
        idle(3);
        for (int i = 0; i < 5; i++) put(OP_WRITE, V1_FREQ_LO, 8'(8'h40 + i));
        idle(1);
        chk("t4 level", 32'(level_o), 32'd5);
        pulse_flush();
        chk("t4 level after flush", 32'(level_o), 32'd0);
        chk("t4 busy after flush", 32'(busy_o), 32'd0);
        n0 = nwr;
        en_mode = 1;
        idle(40);
        chk("t4 no writes", 32'(nwr - n0), 32'd0);

        // Flush while a write is held: the write still lands.
        en_mode = 0;
        put(OP_WRITE, V1_AD, 8'h0F);
        idle(3);
        chk("t5 held", 32'(rw_no), 32'd0);
        pulse_flush();
        idle(2);
        chk("t5 held after flush", 32'(rw_no), 32'd0);
        n0 = nwr;
        en_mode = 1;
        idle(10);
        chk("t5 write completed", 32'(nwr - n0), 32'd1);
        chk("t5 ad reg", 32'(regs[V1_AD]), 32'h0F);

        // Reset while a write is held: outputs drop to reset values at once.
        en_mode = 0;
        put(OP_WRITE, V1_SR, 8'hF0);
        idle(3);
        chk("t5 sr held", 32'(rw_no), 32'd0);
        @(posedge clk8); #2;
        reset_i = 1'b1;
        #1;
        chk("t5 async rw_no", 32'(rw_no), 32'd1);
        chk("t5 async addr", 32'(addr_o), 32'd0);
        chk("t5 async data", 32'(data_o), 32'd0);
        chk("t5 async level", 32'(level_o), 32'd0);
        chk("t5 async ready", 32'(cmd_ready_o), 32'd1);
        idle(2);
        reset_i = 1'b0;

        // MARK between writes.
        en_mode = 1;
        n0 = nmark;
        put(OP_WRITE, V1_CTRL, 8'h11);
        put(OP_MARK, 5'd0, 8'hA5);
        put(OP_WRITE, V1_CTRL, 8'h10);
        idle(40);
        chk("t6 mark count", 32'(nmark - n0), 32'd1);
        chk("t6 mark gap", 32'(mark_gap), 32'd1);
        chk("t6 mark tag", 32'(mark_tag_o), 32'hA5);

        // Randomised traffic, alternating stalled and random strobes.
        for (int i = 0; i < 3000; i++) begin
            en_mode = ((i / 150) % 2 == 0) ? 2 : 0;
            @(posedge clk8); #2;
            cmd_valid_i = ($urandom_range(0, 1) == 1);
            cmd_op_i    = 2'($urandom_range(0, 3));
            cmd_addr_i  = (cmd_op_i == 2'd1) ? 5'd0 : 5'($urandom_range(0, 31));
            cmd_data_i  = (cmd_op_i == 2'd1) ? 8'($urandom_range(0, 4)) : 8'($urandom_range(0, 255));
            flush_i     = ($urandom_range(0, 63) == 0);
        end
        idle(5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
